// File: rtl/maxnet_collector.sv
// maxnet_collector: sequences MAXNET competition iterations through external PLUs and reports the winner or abort cause
module maxnet_collector #(
  parameter int MAX_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] x4,
  input  logic [31:0] plu_out1,
  input  logic [31:0] plu_out2,
  input  logic [31:0] plu_out3,
  input  logic [31:0] plu_out4,
  input  logic        plu_valid,
  input  logic        plu_overflow,
  output logic [31:0] a1,
  output logic [31:0] a2,
  output logic [31:0] a3,
  output logic [31:0] a4,
  output logic        a_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] winner_val,
  output logic        err,
  output logic [1:0]  err_code
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE, ERR} state_t;
  state_t state;
  logic [3:0][31:0] act;
  logic [5:0] iter;
  logic [3:0] live;
  logic [2:0] n_live;
  logic [1:0] idx;
  assign {a4, a3, a2, a1} = act;
  assign a_valid = state == ISSUE;
  assign busy = state == CHECK || state == ISSUE || state == WAIT;
  always_comb begin
    live = '0;
    for (int i = 0; i < 4; i++) live[i] = $signed(act[i]) > 32'sd0;
    n_live = 3'(live[0]) + 3'(live[1]) + 3'(live[2]) + 3'(live[3]);
    idx = live[0] ? 2'd0 : live[1] ? 2'd1 : live[2] ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      act <= '0;
      iter <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
      winner <= '0;
      winner_val <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          act <= {x4, x3, x2, x1};
          iter <= '0;
          done <= 1'b0;
          err <= 1'b0;
          err_code <= '0;
          state <= CHECK;
        end
        CHECK: if (n_live == 3'd1) begin
          winner <= idx;
          winner_val <= act[idx];
          done <= 1'b1;
          state <= DONE;
        end else if (n_live == 3'd0) begin
          err <= 1'b1;
          err_code <= 2'b10;
          state <= ERR;
        end else if (iter == 6'(MAX_ITER)) begin
          err <= 1'b1;
          err_code <= 2'b11;
          state <= ERR;
        end else begin
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (plu_valid && plu_overflow) begin
          err <= 1'b1;
          err_code <= 2'b01;
          state <= ERR;
        end else if (plu_valid) begin
          act <= {plu_out4, plu_out3, plu_out2, plu_out1};
          iter <= iter + 6'd1;
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxnet_collector.sv
// tb_maxnet_collector: directed scenarios with a PLU responder and a scoreboard monitor
module tb_maxnet_collector;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] x1 = 0, x2 = 0, x3 = 0, x4 = 0;
  logic [31:0] plu_out1 = 0, plu_out2 = 0, plu_out3 = 0, plu_out4 = 0;
  logic plu_valid = 0, plu_overflow = 0;
  logic [31:0] a1, a2, a3, a4, winner_val;
  logic a_valid, busy, done, err;
  logic [1:0] winner, err_code;
  typedef struct {
    logic d;
    logic e;
    logic [1:0] code;
    logic [1:0] win;
    logic [31:0] wval;
    int nav;
    logic [3:0][31:0] a;
  } exp_t;
  typedef struct {
    logic [3:0][31:0] o;
    logic ovf;
    int dly;
  } rsp_t;
  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int nchk = 0, nfail = 0, nav = 0;
  logic prev_busy = 0, prev_de = 0;
  maxnet_collector dut (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .plu_out1(plu_out1), .plu_out2(plu_out2), .plu_out3(plu_out3), .plu_out4(plu_out4),
    .plu_valid(plu_valid), .plu_overflow(plu_overflow),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a_valid(a_valid), .busy(busy), .done(done),
    .winner(winner), .winner_val(winner_val), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [159:0] got, logic [159:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) nav = 0;
    if (a_valid) nav++;
    if ((done || err) && !prev_de) begin
      if (exp_q.size() == 0) chk("unexpected_result", {done, err}, 0);
      else begin
        e = exp_q.pop_front();
        chk("outcome", {done, err, err_code}, {e.d, e.e, e.code});
        if (e.d) chk("winner", {winner, winner_val}, {e.win, e.wval});
        chk("a_valid_pulses", nav, e.nav);
        chk("act", {a4, a3, a2, a1}, e.a);
      end
    end
    prev_busy = busy;
    prev_de = done || err;
  end
  always begin
    rsp_t r;
    @(negedge clk);
    if (a_valid && rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      repeat (r.dly) @(negedge clk);
      {plu_out4, plu_out3, plu_out2, plu_out1} = r.o;
      plu_overflow = r.ovf;
      plu_valid = 1;
      @(negedge clk);
      plu_valid = 0;
      plu_overflow = 0;
    end
  end
  task automatic push_exp(input logic d, input logic [1:0] code, input logic [1:0] win,
                          input logic [31:0] wval, input int n, input logic [3:0][31:0] a);
    exp_t e;
    e.d = d; e.e = !d; e.code = code; e.win = win; e.wval = wval; e.nav = n; e.a = a;
    exp_q.push_back(e);
  endtask
  task automatic push_rsp(input logic [3:0][31:0] o, input logic ovf, input int dly);
    rsp_t r;
    r.o = o; r.ovf = ovf; r.dly = dly;
    rsp_q.push_back(r);
  endtask
  task automatic kick(input logic [3:0][31:0] x);
    @(negedge clk);
    {x4, x3, x2, x1} = x;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic finish_wait(output int cyc);
    cyc = 0;
    while (!(done || err) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("timeout", 1, 0);
  endtask
  task automatic wait_av();
    int n = 0;
    while (!a_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("a_valid_timeout", 1, 0);
  endtask
  initial begin
    int cyc;
    {x4, x3, x2, x1} = {32'd0, 32'd0, 32'd5, 32'd0};
    start = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, a_valid, err_code, winner, winner_val, a1, a2, a3, a4}, 0);
    rst = 0;
    start = 0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, err}, 0);
    push_exp(1, 2'b00, 2'd1, 32'd5, 0, {32'd0, 32'd0, 32'd5, 32'd0});
    kick({32'd0, 32'd0, 32'd5, 32'd0});
    finish_wait(cyc);
    chk("latency_one_live", cyc, 1);
    push_rsp({32'd0, 32'd0, 32'd4, 32'd7}, 0, 1);
    push_rsp({32'd0, 32'd0, 32'd1, 32'd5}, 0, 1);
    push_rsp({32'd0, 32'd0, 32'd0, 32'd4}, 0, 1);
    push_exp(1, 2'b00, 2'd0, 32'd4, 3, {32'd0, 32'd0, 32'd0, 32'd4});
    kick({32'd1, 32'd3, 32'd8, 32'd10});
    finish_wait(cyc);
    for (int i = 0; i < 32; i++) push_rsp({32'd0, 32'd0, 32'd4, 32'd4}, 0, 1);
    push_exp(0, 2'b11, 2'd0, 32'd0, 32, {32'd0, 32'd0, 32'd4, 32'd4});
    kick({32'd0, 32'd0, 32'd4, 32'd4});
    finish_wait(cyc);
    push_rsp({32'd1, 32'd1, 32'd1, 32'd1}, 1, 1);
    push_exp(0, 2'b01, 2'd0, 32'd0, 1, {32'd0, 32'd2, 32'd6, 32'd9});
    kick({32'd0, 32'd2, 32'd6, 32'd9});
    finish_wait(cyc);
    push_rsp({32'd0, 32'd0, 32'd0, 32'd0}, 0, 4);
    push_exp(0, 2'b10, 2'd0, 32'd0, 1, {32'd0, 32'd0, 32'd0, 32'd0});
    kick({32'd0, 32'd1, 32'd2, 32'd3});
    wait_av();
    @(negedge clk);
    chk("busy_in_wait", {busy, a_valid}, 2'b10);
    {x4, x3, x2, x1} = {32'd0, 32'd0, 32'd7, 32'd0};
    start = 1;
    @(negedge clk);
    start = 0;
    finish_wait(cyc);
    push_exp(0, 2'b10, 2'd0, 32'd0, 0, {32'hFFFFFFFE, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF});
    kick({32'hFFFFFFFE, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF});
    finish_wait(cyc);
    push_rsp({32'd0, 32'd0, 32'd0, 32'd1}, 0, 3);
    kick({32'd0, 32'd0, 32'd5, 32'd6});
    wait_av();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_abort_idle", {busy, done, err, a_valid, err_code, winner, winner_val, a1, a2, a3, a4}, 0);
    push_exp(1, 2'b00, 2'd1, 32'd2, 0, {32'd0, 32'd0, 32'd2, 32'hFFFFFFFD});
    kick({32'd0, 32'd0, 32'd2, 32'hFFFFFFFD});
    finish_wait(cyc);
    chk("latency_after_rst", cyc, 1);
    repeat (5) @(negedge clk);
    chk("queues_drained", {exp_q.size(), rsp_q.size()}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
